// File: rtl/pwm_pr_demod.sv
// pwm_pr_demod: receiver for a bit-reversed-counter PWM stream.
// It counts the ones in the stream over fixed windows of `period` clocks.
// Each completed window is handed downstream as the recovered duty value
// through a valid/ready handshake.
module pwm_pr_demod #(
   parameter int period      = 16,
   parameter int sync_stages = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in,
   output logic [$clog2(period)-1:0]  out,
   output logic                       valid,
   input  logic                       ready,
   output logic                       sat,
   output logic                       ovf
);

   localparam int n = $clog2(period);

   // The last window slot doubles as the saturated result, because the
   // modulator can never legitimately produce more than period-1 ones.
   localparam logic [n-1:0] wcnt_last  = (n)'(period - 1);
   localparam logic [n-1:0] wcnt_one   = (n)'(1);
   localparam logic [n:0]   full_count = (n + 1)'(period);

   logic s;

   // The input may come from another board, so it is retimed unless the
   // stream is already known to be in this clock domain.
   generate
      if (sync_stages == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [sync_stages-1:0] sync_q;
         logic [sync_stages-1:0] sync_d;

         // Shift the raw input one stage along the synchronizer chain.
         always_comb begin
            sync_d    = sync_q;
            sync_d[0] = in;
            for (int i = 1; i < sync_stages; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         // Synchronizer flops; cleared on reset so no stale bit leaks into the first window.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else begin
               sync_q <= sync_d;
            end
         end

         assign s = sync_q[sync_stages-1];
      end
   endgenerate

   logic [n-1:0] wcnt_q, wcnt_d;
   logic [n:0]   acc_q, acc_d;
   logic [n-1:0] out_q, out_d;
   logic         valid_q, valid_d;
   logic         sat_q, sat_d;
   logic         ovf_q, ovf_d;

   logic         win_close;
   logic [n:0]   total;
   logic         rsat;
   logic [n-1:0] result;

   // Window counting, accumulation and the single-entry output register.
   always_comb begin
      wcnt_d  = wcnt_q + wcnt_one;
      total   = acc_q + {{n{1'b0}}, s};
      rsat    = (total == full_count);
      result  = rsat ? wcnt_last : total[n-1:0];
      win_close = (wcnt_q == wcnt_last);

      acc_d   = (wcnt_q == '0) ? {{n{1'b0}}, s} : total;
      out_d   = out_q;
      valid_d = valid_q;
      sat_d   = sat_q;
      ovf_d   = ovf_q;

      if (valid_q && ready) begin
         valid_d = 1'b0;
      end

      if (win_close) begin
         if (!valid_q || ready) begin
            out_d   = result;
            sat_d   = rsat;
            valid_d = 1'b1;
         end else begin
            ovf_d   = 1'b1;
         end
      end
   end

   // State registers; reset discards any partial window and restarts at slot 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wcnt_q  <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wcnt_q  <= wcnt_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign sat   = sat_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_pwm_pr_demod.sv
// Testbench for pwm_pr_demod: one instance with a 2-stage synchronizer and
// one without. Both are fed from a behavioural bit-reversed PWM modulator.
// Every cycle both instances are compared against a window-sum reference model.
module tb_pwm_pr_demod;

   localparam int P = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_s;
   logic       ready;
   logic [3:0] out2, out0;
   logic       valid2, valid0, sat2, sat0, ovf2, ovf0;

   always #5 clk = ~clk;

   pwm_pr_demod #(.period(P), .sync_stages(2)) dut (
      .clk(clk), .rst_n(rst_n), .in(in_s), .out(out2), .valid(valid2),
      .ready(ready), .sat(sat2), .ovf(ovf2)
   );

   pwm_pr_demod #(.period(P), .sync_stages(0)) dut_nosync (
      .clk(clk), .rst_n(rst_n), .in(in_s), .out(out0), .valid(valid0),
      .ready(ready), .sat(sat0), .ovf(ovf0)
   );

   int n_checks = 0;
   int n_fails  = 0;

   // Modulator state: duty value, counter phase, optional forced level (-1 = none).
   int         duty = 0;
   int         force_mode = -1;
   logic [3:0] mcnt = 4'd0;

   // Reference model: raw samples since reset release and per-instance result slot.
   int  e = 0;
   bit  hist[$];
   int  sdly[2] = '{2, 0};
   int  m_out[2];
   bit  m_valid[2];
   bit  m_sat[2];
   bit  m_ovf[2];

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Stream bit seen by the counter of instance d at edge t after release.
   function automatic int streamBit(input int d, input int t);
      if (t < sdly[d]) return 0;
      return int'(hist[t - sdly[d]]);
   endfunction

   task automatic modelStep();
      int total;
      if (!rst_n) begin
         e = 0;
         hist.delete();
         for (int d = 0; d < 2; d++) begin
            m_out[d] = 0; m_valid[d] = 0; m_sat[d] = 0; m_ovf[d] = 0;
         end
      end else begin
         hist.push_back(in_s);
         for (int d = 0; d < 2; d++) begin
            if (e % P == P - 1) begin
               total = 0;
               for (int t = e - (P - 1); t <= e; t++) total += streamBit(d, t);
               if (!m_valid[d] || ready) begin
                  m_out[d]   = (total >= P) ? P - 1 : total;
                  m_sat[d]   = (total == P);
                  m_valid[d] = 1;
               end else begin
                  m_ovf[d] = 1;
               end
            end else if (m_valid[d] && ready) begin
               m_valid[d] = 0;
            end
         end
         e++;
      end
   endtask

   task automatic compareAll();
      checkOutput("out_s2",   {28'd0, out2}, m_out[0]);
      checkOutput("valid_s2", {31'd0, valid2}, {31'd0, m_valid[0]});
      checkOutput("sat_s2",   {31'd0, sat2},   {31'd0, m_sat[0]});
      checkOutput("ovf_s2",   {31'd0, ovf2},   {31'd0, m_ovf[0]});
      checkOutput("out_s0",   {28'd0, out0}, m_out[1]);
      checkOutput("valid_s0", {31'd0, valid0}, {31'd0, m_valid[1]});
      checkOutput("sat_s0",   {31'd0, sat0},   {31'd0, m_sat[1]});
      checkOutput("ovf_s0",   {31'd0, ovf0},   {31'd0, m_ovf[1]});
   endtask

   // Drive the modulator bit, let the edge happen, update the model, then compare.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if (force_mode >= 0) in_s = (force_mode != 0);
         else in_s = (int'({mcnt[0], mcnt[1], mcnt[2], mcnt[3]}) < duty);
         mcnt = mcnt + 4'd1;
         @(posedge clk);
         modelStep();
         @(negedge clk);
         compareAll();
      end
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      ready = 1'b1;
      in_s  = 1'b0;
      applyStimulus(3);
      checkOutput("reset_out",   {28'd0, out2}, 0);
      checkOutput("reset_valid", {31'd0, valid2}, 0);
      checkOutput("reset_ovf",   {31'd0, ovf2}, 0);

      // Duty 5 at an arbitrary modulator phase.
      $display("[TB] duty 5, random phase");
      mcnt  = 4'($urandom_range(0, 15));
      duty  = 5;
      rst_n = 1'b1;
      applyStimulus(100);
      checkOutput("t1_out2", {28'd0, out2}, 5);
      checkOutput("t1_sat2", {31'd0, sat2}, 0);
      checkOutput("t1_out0", {28'd0, out0}, 5);

      // Duty 0 then full-scale 15.
      $display("[TB] duty 0 then 15");
      duty = 0;
      applyStimulus(40);
      checkOutput("t2_out_zero", {28'd0, out2}, 0);
      duty = 15;
      applyStimulus(40);
      checkOutput("t2_out_max", {28'd0, out2}, 15);
      checkOutput("t2_sat_max", {31'd0, sat2}, 0);

      // Stuck-high stream saturates, then stuck-low reads zero.
      $display("[TB] forced stream");
      force_mode = 1;
      applyStimulus(40);
      checkOutput("t3_out_high", {28'd0, out2}, 15);
      checkOutput("t3_sat_high", {31'd0, sat2}, 1);
      checkOutput("t3_sat_high0", {31'd0, sat0}, 1);
      force_mode = 0;
      applyStimulus(40);
      checkOutput("t3_out_low", {28'd0, out2}, 0);
      checkOutput("t3_sat_low", {31'd0, sat2}, 0);

      // Back-pressure: result held, overflow becomes sticky.
      $display("[TB] back-pressure");
      force_mode = -1;
      duty = 9;
      applyStimulus(40);
      checkOutput("t4_ovf_before", {31'd0, ovf2}, 0);
      ready = 1'b0;
      applyStimulus(48);
      checkOutput("t4_out_held",   {28'd0, out2}, 9);
      checkOutput("t4_valid_held", {31'd0, valid2}, 1);
      checkOutput("t4_ovf_set",    {31'd0, ovf2}, 1);
      ready = 1'b1;
      applyStimulus(20);
      checkOutput("t4_out_fresh", {28'd0, out2}, 9);
      checkOutput("t4_ovf_stuck", {31'd0, ovf2}, 1);

      // One-cycle reset in the middle of a window at slot 7.
      $display("[TB] mid-window reset");
      duty = 12;
      for (int i = 0; i < 40; i++) begin
         if (e % P == 7) break;
         applyStimulus(1);
      end
      checkOutput("t5_slot", e % P, 7);
      rst_n = 1'b0;
      applyStimulus(1);
      checkOutput("t5_out_clr",   {28'd0, out2}, 0);
      checkOutput("t5_valid_clr", {31'd0, valid2}, 0);
      checkOutput("t5_sat_clr",   {31'd0, sat2}, 0);
      checkOutput("t5_ovf_clr",   {31'd0, ovf2}, 0);
      rst_n = 1'b1;
      applyStimulus(15);
      checkOutput("t5_not_yet", {31'd0, valid2}, 0);
      applyStimulus(1);
      checkOutput("t5_first_valid", {31'd0, valid2}, 1);
      applyStimulus(16);
      checkOutput("t5_out_full", {28'd0, out2}, 12);

      // Unsynchronized instance: latency from reset release to first result.
      $display("[TB] latency without synchronizer");
      ready = 1'b0;
      duty  = 3;
      rst_n = 1'b0;
      applyStimulus(2);
      rst_n = 1'b1;
      mcnt  = 4'd0;
      lat   = 0;
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(1);
         if (valid0 === 1'b1) begin
            lat = i;
            break;
         end
      end
      checkOutput("t6_latency", lat, 16);
      checkOutput("t6_out", {28'd0, out0}, 3);

      // Randomized duty, forcing and back-pressure.
      $display("[TB] random traffic");
      rst_n = 1'b0;
      applyStimulus(1);
      rst_n = 1'b1;
      for (int seg = 0; seg < 20; seg++) begin
         duty       = $urandom_range(0, 15);
         force_mode = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
         for (int c = 0; c < 20; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            applyStimulus(1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
